// File: rtl/dm_pkg.sv
// Shared constants and address-select codes for the data memory / stack block.
package dm_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] SP_INIT = 8'hFF;

  typedef enum logic [1:0] {
    ADDR_LIT  = 2'b00,
    ADDR_REGB = 2'b01,
    ADDR_SP   = 2'b10,
    ADDR_SP1  = 2'b11
  } addr_sel_e;

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer with saturating push/pop, empty/full decode and sticky
// overflow/underflow flags.
module stack_pointer
  import dm_pkg::*;
#(
  parameter int              SP_ADDR_W = dm_pkg::ADDR_W,
  parameter logic [SP_ADDR_W-1:0] SP_RESET = dm_pkg::SP_INIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  input  logic                 dec_i,
  input  logic                 clr_err_i,
  output logic [SP_ADDR_W-1:0] sp_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 ovf_o,
  output logic                 udf_o
);

  logic [SP_ADDR_W-1:0] sp_q, sp_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  // A clear and a fresh error on the same edge leave the flag set.
  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (dec_i && !inc_i) begin
      if (sp_q != '0) sp_d = sp_q - SP_ADDR_W'(1);
      else            ovf_d = 1'b1;
    end else if (inc_i && !dec_i) begin
      if (sp_q != SP_RESET) sp_d = sp_q + SP_ADDR_W'(1);
      else                  udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q  <= SP_RESET;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign sp_o    = sp_q;
  assign empty_o = (sp_q == SP_RESET);
  assign full_o  = (sp_q == '0);
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule

// File: rtl/data_mem_stack.sv
// Data memory with asynchronous read feeding mux B, synchronous write, and an
// integrated stack pointer for PUSH/POP/CALL/RET.
module data_mem_stack
  import dm_pkg::*;
#(
  parameter int                DATA_W  = dm_pkg::DATA_W,
  parameter int                ADDR_W  = dm_pkg::ADDR_W,
  parameter int                DEPTH   = 2 ** ADDR_W,
  parameter logic [ADDR_W-1:0] SP_INIT = dm_pkg::SP_INIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        addr_sel,
  input  logic [ADDR_W-1:0] lit,
  input  logic [ADDR_W-1:0] regB,
  input  logic [DATA_W-1:0] din,
  input  logic              w,
  input  logic              sp_inc,
  input  logic              sp_dec,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              ovf,
  output logic              udf
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] spPlus1;

  stack_pointer #(
    .SP_ADDR_W (ADDR_W),
    .SP_RESET  (SP_INIT)
  ) u_sp (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (sp_inc),
    .dec_i     (sp_dec),
    .clr_err_i (clr_err),
    .sp_o      (sp),
    .empty_o   (stack_empty),
    .full_o    (stack_full),
    .ovf_o     (ovf),
    .udf_o     (udf)
  );

  // SP+1 wraps, so a pop from an empty stack addresses word 0.
  assign spPlus1 = sp + ADDR_W'(1);

  always_comb begin
    addr = lit;
    case (addr_sel_e'(addr_sel))
      ADDR_LIT:  addr = lit;
      ADDR_REGB: addr = regB;
      ADDR_SP:   addr = sp;
      ADDR_SP1:  addr = spPlus1;
      default:   addr = lit;
    endcase
  end

  // Memory contents survive reset; reset only blocks the write on its edge.
  always_ff @(posedge clk) begin
    if (rst_n && w) begin
      mem_q[addr] <= din;
    end
  end

  assign dout = mem_q[addr];

endmodule

// File: tb/tb_data_mem_stack.sv
// Scoreboard bench for data_mem_stack: stimulus queues expectations, a
// negedge monitor pops and compares them.
module tb_data_mem_stack;

  logic       clk;
  logic       rst_n;
  logic [1:0] addr_sel;
  logic [7:0] lit, regB, din;
  logic       w, sp_inc, sp_dec, clr_err;
  logic [7:0] dout, sp;
  logic       stack_empty, stack_full, ovf, udf;

  typedef struct {
    string      name;
    bit         chkDout;
    logic [7:0] dout;
    bit         chkState;
    logic [7:0] sp;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  data_mem_stack dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr_sel    (addr_sel),
    .lit         (lit),
    .regB        (regB),
    .din         (din),
    .w           (w),
    .sp_inc      (sp_inc),
    .sp_dec      (sp_dec),
    .clr_err     (clr_err),
    .dout        (dout),
    .sp          (sp),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .ovf         (ovf),
    .udf         (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: every expectation queued for this cycle is checked mid-cycle.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      if (e.chkDout) checkOutput({e.name, ".dout"}, dout, e.dout);
      if (e.chkState) begin
        checkOutput({e.name, ".sp"},    sp,                 e.sp);
        checkOutput({e.name, ".empty"}, {7'd0, stack_empty}, {7'd0, e.empty});
        checkOutput({e.name, ".full"},  {7'd0, stack_full},  {7'd0, e.full});
        checkOutput({e.name, ".ovf"},   {7'd0, ovf},         {7'd0, e.ovf});
        checkOutput({e.name, ".udf"},   {7'd0, udf},         {7'd0, e.udf});
      end
    end
  end

  task automatic applyStimulus(input logic rstn, input logic [1:0] sel, input logic [7:0] litV,
                               input logic [7:0] regBV, input logic [7:0] dinV, input logic wV,
                               input logic inc, input logic dec, input logic clr);
    rst_n    = rstn;
    addr_sel = sel;
    lit      = litV;
    regB     = regBV;
    din      = dinV;
    w        = wV;
    sp_inc   = inc;
    sp_dec   = dec;
    clr_err  = clr;
  endtask

  task automatic expectDout(input string name, input logic [7:0] v);
    exp_t e;
    e = '{name: name, chkDout: 1'b1, dout: v, chkState: 1'b0,
          sp: 8'h00, empty: 1'b0, full: 1'b0, ovf: 1'b0, udf: 1'b0};
    expQ.push_back(e);
  endtask

  task automatic expectState(input string name, input logic [7:0] spV, input logic e_, input logic f_,
                             input logic o_, input logic u_);
    exp_t e;
    e = '{name: name, chkDout: 1'b0, dout: 8'h00, chkState: 1'b1,
          sp: spV, empty: e_, full: f_, ovf: o_, udf: u_};
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] litV);
    applyStimulus(1'b1, 2'b00, litV, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] v);
    applyStimulus(1'b1, 2'b10, 8'h00, 8'h00, v, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pop();
    applyStimulus(1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset, then seed mem[FF] so the dirty reset edge can be shown not to write.
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expectState("reset0", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 8'hFF, 8'h00, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b10, 8'h00, 8'h00, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0);
    expectDout("preReset", 8'h33);
    tick();
    idle(8'hFF);
    expectDout("resetNoWrite", 8'h33);
    expectState("resetDirty", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Literal and register-B addressing.
    applyStimulus(1'b1, 2'b00, 8'h10, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle(8'h10);
    expectDout("litRead", 8'hA5);
    tick();
    applyStimulus(1'b1, 2'b01, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    expectDout("regBRead", 8'hA5);
    tick();

    // Push/pop pair.
    push(8'h11);
    tick();
    push(8'h22);
    tick();
    idle(8'hFF);
    expectState("afterPush", 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0);
    expectDout("memFF", 8'h11);
    tick();
    idle(8'hFE);
    expectDout("memFE", 8'h22);
    tick();
    pop();
    expectDout("pop1", 8'h22);
    tick();
    pop();
    expectState("afterPop1", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    expectDout("pop2", 8'h11);
    tick();
    idle(8'h00);
    expectState("afterPop2", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Fill the stack: push number i lands at mem[FF-i].
    for (int i = 0; i < 255; i++) begin
      push(8'(i));
      tick();
    end
    idle(8'h80);
    expectState("full", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expectDout("mem80", 8'h7F);
    tick();
    push(8'h5A);
    tick();
    idle(8'h00);
    expectState("ovfSet", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    expectDout("mem00", 8'h5A);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(8'h00);
      expectState("ovfHold", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle(8'h00);
    expectState("ovfClr", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Underflow, then clear racing a new underflow.
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    expectDout("popEmptyWrap", 8'h5A);
    tick();
    applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    expectState("udfSet", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle(8'h00);
    expectState("udfSetWins", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle(8'h00);
    expectState("udfClr", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // Walk SP down to 80 without writing, then inc+dec together.
    for (int i = 0; i < 127; i++) begin
      applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    expectState("sp80", 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle(8'h00);
    expectState("incDec", 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Read-during-write to the same address.
    applyStimulus(1'b1, 2'b00, 8'h30, 8'h00, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b00, 8'h30, 8'h00, 8'h88, 1'b1, 1'b0, 1'b0, 1'b0);
    expectDout("rdwOld", 8'h77);
    tick();
    idle(8'h30);
    expectDout("rdwNew", 8'h88);
    tick();

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
